// File: rtl/modinv_issue.sv
// Modular-inverse issue stage: queues {src,dst} jobs, reads the operand, launches the
// inverter and writes the result back. Optional WAIT timeout under MODINV_ISSUE_TIMEOUT_EN.
`ifndef WORDSZ
`define WORDSZ 16
`endif
`ifndef RFSZLOG2
`define RFSZLOG2 4
`endif

module modinv_issue #(
  parameter int QDEPTH  = 4,
  parameter int RD_LAT  = 3,
  parameter int TIMEOUT = `WORDSZ*2+16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [`RFSZLOG2-1:0] req_src,
  input  logic [`RFSZLOG2-1:0] req_dst,
  output logic                 rf_ren,
  output logic [`RFSZLOG2-1:0] rf_raddr,
  input  logic [`WORDSZ-1:0]   rf_rdata,
  output logic                 inv_en,
  output logic [`WORDSZ-1:0]   inv_a,
  output logic [`RFSZLOG2-1:0] inv_rn,
  input  logic                 inv_done,
  input  logic [`WORDSZ-1:0]   inv_res,
  input  logic [`RFSZLOG2-1:0] inv_rn_in,
  output logic                 rf_wen,
  output logic [`RFSZLOG2-1:0] rf_waddr,
  output logic [`WORDSZ-1:0]   rf_wdata,
  output logic                 busy,
  output logic                 zero_err,
  output logic                 rn_err,
  output logic                 timeout_err
);
  localparam int AW  = $clog2(QDEPTH);
  localparam int RW  = `RFSZLOG2;
  localparam int RCW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [AW:0]    FULL    = (AW+1)'(QDEPTH);
  localparam logic [RCW-1:0] RD_LAST = RCW'(RD_LAT);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LAUNCH, S_WAIT, S_WB} state_t;

  state_t             r_state;
  logic [2*RW-1:0]    r_mem [QDEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_count, w_count_nxt;
  logic               r_ready;
  logic [RW-1:0]      r_dst;
  logic [RCW-1:0]     r_rd_cnt;
  logic               r_rf_ren, r_inv_en, r_rf_wen;
  logic [RW-1:0]      r_rf_raddr, r_inv_rn, r_rf_waddr;
  logic [`WORDSZ-1:0] r_inv_a, r_rf_wdata;
  logic               r_zero_err, r_rn_err;
  logic               w_push, w_pop;
  logic [RW-1:0]      w_head_src, w_head_dst;

`ifdef MODINV_ISSUE_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);
  logic [TCW-1:0] r_to_cnt;
  logic           r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign w_push = req_valid & r_ready;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign {w_head_src, w_head_dst} = r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {req_src, req_dst};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_dst      <= '0;
      r_rd_cnt   <= '0;
      r_rf_ren   <= 1'b0;
      r_rf_raddr <= '0;
      r_inv_en   <= 1'b0;
      r_inv_a    <= '0;
      r_inv_rn   <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_zero_err <= 1'b0;
      r_rn_err   <= 1'b0;
`ifdef MODINV_ISSUE_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < FULL);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // Strobes and their data default low; a state transition raises them for one cycle.
      r_rf_ren   <= 1'b0;
      r_rf_raddr <= '0;
      r_inv_en   <= 1'b0;
      r_inv_a    <= '0;
      r_inv_rn   <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_zero_err <= 1'b0;
      r_rn_err   <= 1'b0;
`ifdef MODINV_ISSUE_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_dst      <= w_head_dst;
          r_rd_cnt   <= '0;
          r_rf_ren   <= 1'b1;
          r_rf_raddr <= w_head_src;
          r_state    <= S_READ;
        end
        S_READ: if (r_rd_cnt == RD_LAST) begin
          if (rf_rdata == '0) begin
            r_rf_wen   <= 1'b1;
            r_rf_waddr <= r_dst;
            r_zero_err <= 1'b1;
            r_state    <= S_WB;
          end else begin
            r_inv_en <= 1'b1;
            r_inv_a  <= rf_rdata;
            r_inv_rn <= r_dst;
            r_state  <= S_LAUNCH;
          end
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
        S_LAUNCH: begin
`ifdef MODINV_ISSUE_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: if (inv_done) begin
          r_rf_wen   <= 1'b1;
          r_rf_waddr <= r_dst;
          r_rf_wdata <= inv_res;
          r_rn_err   <= (inv_rn_in != r_dst);
          r_state    <= S_WB;
        end
`ifdef MODINV_ISSUE_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          r_rf_wen      <= 1'b1;
          r_rf_waddr    <= r_dst;
          r_timeout_err <= 1'b1;
          r_state       <= S_WB;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
`endif
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rf_ren    = r_rf_ren;
  assign rf_raddr  = r_rf_raddr;
  assign inv_en    = r_inv_en;
  assign inv_a     = r_inv_a;
  assign inv_rn    = r_inv_rn;
  assign rf_wen    = r_rf_wen;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign zero_err  = r_zero_err;
  assign rn_err    = r_rn_err;
  assign busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule
